// File: rtl/imuldiv_mul_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier between two requesters.
// Optional zero-operand bypass: define IMULDIV_ARB_ZERO_BYPASS_EN.
module imuldiv_mul_arbiter #(
  parameter int OP_W  = 32,
  parameter int RES_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  req0_msg_a,
  input  logic [OP_W-1:0]  req0_msg_b,
  input  logic             req0_val,
  output logic             req0_rdy,
  output logic [RES_W-1:0] resp0_msg_result,
  output logic             resp0_val,
  input  logic             resp0_rdy,
  input  logic [OP_W-1:0]  req1_msg_a,
  input  logic [OP_W-1:0]  req1_msg_b,
  input  logic             req1_val,
  output logic             req1_rdy,
  output logic [RES_W-1:0] resp1_msg_result,
  output logic             resp1_val,
  input  logic             resp1_rdy,
  output logic [OP_W-1:0]  mul_msg_a,
  output logic [OP_W-1:0]  mul_msg_b,
  output logic             mul_val,
  input  logic             mul_rdy,
  input  logic [RES_W-1:0] mul_resp_msg_result,
  input  logic             mul_resp_val,
  output logic             mul_resp_rdy,
  output logic             owner,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_r;
  state_t             state_s;
  logic               prio_r;
  logic               owner_r;
  logic [OP_W-1:0]    a_r;
  logic [OP_W-1:0]    b_r;
  logic [RES_W-1:0]   result_r;

  logic               grant_s;
  logic [OP_W-1:0]    sel_a_s;
  logic [OP_W-1:0]    sel_b_s;
  logic               fire_s;
  logic               resp_fire_s;
  logic               zero_s;

  // Arbitration, handshake qualification and next-state selection
  always_comb begin
    grant_s     = prio_r;
    sel_a_s     = req0_msg_a;
    sel_b_s     = req0_msg_b;
    fire_s      = 1'b0;
    resp_fire_s = 1'b0;
    zero_s      = 1'b0;
    state_s     = state_r;

    if (req0_val && !req1_val) begin
      grant_s = 1'b0;
    end else if (!req0_val && req1_val) begin
      grant_s = 1'b1;
    end else begin
      grant_s = prio_r;
    end

    if (grant_s) begin
      sel_a_s = req1_msg_a;
      sel_b_s = req1_msg_b;
    end else begin
      sel_a_s = req0_msg_a;
      sel_b_s = req0_msg_b;
    end

    fire_s      = !reset && (state_r == IDLE) && (req0_val || req1_val);
    resp_fire_s = !reset && (state_r == RESP) && (owner_r ? resp1_rdy : resp0_rdy);
`ifdef IMULDIV_ARB_ZERO_BYPASS_EN
    zero_s      = (sel_a_s == {OP_W{1'b0}}) || (sel_b_s == {OP_W{1'b0}});
`else
    zero_s      = 1'b0;
`endif

    case (state_r)
      IDLE: begin
        if (fire_s) begin
          state_s = zero_s ? RESP : ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (mul_rdy) begin
          state_s = WAIT;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT: begin
        if (mul_resp_val) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (resp_fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is held, whatever state the FSM is in
  always_comb begin
    req0_rdy         = !reset && (state_r == IDLE) && !grant_s;
    req1_rdy         = !reset && (state_r == IDLE) &&  grant_s;
    mul_val          = !reset && (state_r == ISSUE);
    mul_resp_rdy     = !reset && (state_r == WAIT);
    resp0_val        = !reset && (state_r == RESP) && !owner_r;
    resp1_val        = !reset && (state_r == RESP) &&  owner_r;
    resp0_msg_result = result_r;
    resp1_msg_result = result_r;
    mul_msg_a        = a_r;
    mul_msg_b        = b_r;
    owner            = owner_r;
    busy             = (state_r != IDLE);
  end

  // State, priority, operand and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      prio_r   <= 1'b0;
      owner_r  <= 1'b0;
      a_r      <= {OP_W{1'b0}};
      b_r      <= {OP_W{1'b0}};
      result_r <= {RES_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (fire_s) begin
        a_r     <= sel_a_s;
        b_r     <= sel_b_s;
        owner_r <= grant_s;
        if (zero_s) begin
          result_r <= {RES_W{1'b0}};
        end
      end
      if (mul_resp_rdy && mul_resp_val) begin
        result_r <= mul_resp_msg_result;
      end
      // The requester just served drops to lower priority
      if (resp_fire_s) begin
        prio_r <= ~owner_r;
      end
    end
  end

endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// Self-checking bench for imuldiv_mul_arbiter: request drivers, a behavioural
// multiplier, and per-port result scoreboards.
module tb_imuldiv_mul_arbiter;

  localparam int LAT = 3;

  logic        clk;
  logic        reset;
  logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b;
  logic        req0_val, req0_rdy, req1_val, req1_rdy;
  logic [63:0] resp0_msg_result, resp1_msg_result;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [31:0] mul_msg_a, mul_msg_b;
  logic        mul_val, mul_rdy;
  logic [63:0] mul_resp_msg_result;
  logic        mul_resp_val, mul_resp_rdy;
  logic        owner, busy;

  int checks = 0;
  int fails  = 0;

  logic [63:0] stim0[$], stim1[$];
  logic [63:0] exp0_q[$], exp1_q[$];
  bit          got_order[$];
  logic [63:0] last0, last1;
  int          resp1_seen = 0;
  int          mul_fires  = 0;
  logic        m_busy;
  int          m_cnt;

  imuldiv_mul_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(req0_rdy),
    .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .mul_msg_a(mul_msg_a), .mul_msg_b(mul_msg_b), .mul_val(mul_val), .mul_rdy(mul_rdy),
    .mul_resp_msg_result(mul_resp_msg_result), .mul_resp_val(mul_resp_val),
    .mul_resp_rdy(mul_resp_rdy), .owner(owner), .busy(busy)
  );

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    return sa * sb;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural multiplier: fixed latency, signed product, shares reset
  always @(posedge clk) begin
    if (reset) begin
      m_busy       <= 1'b0;
      m_cnt        <= 0;
      mul_rdy      <= 1'b1;
      mul_resp_val <= 1'b0;
      mul_resp_msg_result <= 64'd0;
    end else if (!m_busy && mul_val && mul_rdy) begin
      m_busy    <= 1'b1;
      mul_rdy   <= 1'b0;
      m_cnt     <= LAT;
      mul_fires <= mul_fires + 1;
      mul_resp_msg_result <= prod(mul_msg_a, mul_msg_b);
    end else if (m_busy && !mul_resp_val) begin
      if (m_cnt == 0) mul_resp_val <= 1'b1;
      else m_cnt <= m_cnt - 1;
    end else if (mul_resp_val && mul_resp_rdy) begin
      mul_resp_val <= 1'b0;
      m_busy       <= 1'b0;
      mul_rdy      <= 1'b1;
    end
  end

  // Request drivers: present queue heads, push expected result on acceptance
  initial begin
    bit acc0, acc1;
    logic [63:0] p;
    req0_val = 1'b0; req1_val = 1'b0;
    req0_msg_a = 32'd0; req0_msg_b = 32'd0; req1_msg_a = 32'd0; req1_msg_b = 32'd0;
    forever begin
      @(negedge clk);
      acc0 = req0_val && req0_rdy && !reset;
      acc1 = req1_val && req1_rdy && !reset;
      @(posedge clk);
      #1;
      if (acc0) begin p = stim0.pop_front(); exp0_q.push_back(prod(p[63:32], p[31:0])); end
      if (acc1) begin p = stim1.pop_front(); exp1_q.push_back(prod(p[63:32], p[31:0])); end
      req0_val = (stim0.size() != 0);
      if (req0_val) {req0_msg_a, req0_msg_b} = stim0[0];
      req1_val = (stim1.size() != 0);
      if (req1_val) {req1_msg_a, req1_msg_b} = stim1[0];
    end
  end

  // Response monitor: every completed response is checked against its port's scoreboard
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset) begin
      if (resp1_val) resp1_seen++;
      if (resp0_val && resp1_val) begin
        checks++; fails++;
        $display("FAIL resp_both_valid: resp0_val=1 resp1_val=1, required at most one");
      end
      if (resp0_val && resp0_rdy) begin
        checks++;
        got_order.push_back(1'b0);
        last0 = resp0_msg_result;
        if (exp0_q.size() == 0) begin
          fails++;
          $display("FAIL resp0_unexpected: got %h, required no response", resp0_msg_result);
        end else begin
          e = exp0_q.pop_front();
          if (resp0_msg_result !== e) begin
            fails++;
            $display("FAIL resp0_result: got %h, required %h", resp0_msg_result, e);
          end
        end
      end
      if (resp1_val && resp1_rdy) begin
        checks++;
        got_order.push_back(1'b1);
        last1 = resp1_msg_result;
        if (exp1_q.size() == 0) begin
          fails++;
          $display("FAIL resp1_unexpected: got %h, required no response", resp1_msg_result);
        end else begin
          e = exp1_q.pop_front();
          if (resp1_msg_result !== e) begin
            fails++;
            $display("FAIL resp1_result: got %h, required %h", resp1_msg_result, e);
          end
        end
      end
    end
  end

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (stim0.size() == 0 && stim1.size() == 0 && exp0_q.size() == 0 &&
          exp1_q.size() == 0 && !busy && !req0_val && !req1_val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp0_q.delete(); exp1_q.delete();
  endtask

  task automatic test_reset();
    logic [5:0] hs;
    reset = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    repeat (3) @(negedge clk);
    hs = {req0_rdy, req1_rdy, resp0_val, resp1_val, mul_val, mul_resp_rdy};
    checks++;
    if (hs !== 6'b0) begin
      fails++; $display("FAIL reset_handshakes: got %b, required 000000", hs);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || owner !== 1'b0 || resp0_msg_result !== 64'd0 || mul_msg_a !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b owner=%b result=%h mul_a=%h, required 0s",
               busy, owner, resp0_msg_result, mul_msg_a);
    end
  endtask

  task automatic test_single();
    bit ok;
    int seen;
    seen = resp1_seen;
    @(negedge clk);
    stim0.push_back({32'd3, 32'hFFFF_FFFB});
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_val && req0_rdy) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || req1_rdy !== 1'b0) begin
      fails++; $display("FAIL single_accept: accepted=%b req1_rdy=%b, required 1 and 0", ok, req1_rdy);
    end
    @(negedge clk);
    checks++;
    if (mul_val !== 1'b1 || owner !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL single_issue_latency: mul_val=%b owner=%b busy=%b, required 1 0 1",
                        mul_val, owner, busy);
    end
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mul_resp_val && mul_resp_rdy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (!ok || resp0_val !== 1'b1) begin
      fails++; $display("FAIL single_resp_latency: mul_resp seen=%b resp0_val=%b, required 1 1", ok, resp0_val);
    end
    wait_drain(ok);
    checks++;
    if (!ok || last0 !== 64'hFFFF_FFFF_FFFF_FFF1 || resp1_seen != seen) begin
      fails++; $display("FAIL single_result: drained=%b result=%h resp1_cycles=%0d, required 1 fffffffffffffff1 0",
                        ok, last0, resp1_seen - seen);
    end
  endtask

  task automatic test_both_same_cycle();
    bit ok;
    pulse_reset();
    got_order.delete();
    @(negedge clk);
    stim0.push_back({32'd2, 32'd7});
    stim1.push_back({32'd6, 32'd9});
    wait_drain(ok);
    checks++;
    if (!ok || got_order.size() != 2 || got_order[0] != 1'b0 || got_order[1] != 1'b1 ||
        last0 !== 64'd14 || last1 !== 64'd54) begin
      fails++; $display("FAIL both_order: drained=%b n=%0d r0=%0d r1=%0d, required 1 2 14 54 port order 0,1",
                        ok, got_order.size(), last0, last1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [3:0] ord;
    got_order.delete();
    @(negedge clk);
    stim0.push_back({32'd11, 32'd13});
    stim0.push_back({32'hFFFF_FFFF, 32'd5});
    stim1.push_back({32'h8000_0000, 32'd2});
    stim1.push_back({32'd123456, 32'd654321});
    wait_drain(ok);
    ord = 4'hF;
    if (got_order.size() == 4) ord = {got_order[0], got_order[1], got_order[2], got_order[3]};
    checks++;
    if (!ok || ord !== 4'b0101) begin
      fails++; $display("FAIL alternate_order: drained=%b order=%b, required 0101", ok, ord);
    end
  endtask

  task automatic test_resp_stall();
    bit ok, hold;
    resp0_rdy = 1'b0;
    @(negedge clk);
    stim0.push_back({32'd5, 32'd6});
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp0_val) begin ok = 1'b1; break; end
    end
    stim1.push_back({32'd2, 32'd3});
    hold = ok;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp0_val !== 1'b1 || resp0_msg_result !== 64'd30 || req0_rdy !== 1'b0 ||
          req1_rdy !== 1'b0 || mul_val !== 1'b0 || resp1_val !== 1'b0) hold = 1'b0;
    end
    checks++;
    if (!hold) begin
      fails++; $display("FAIL resp_hold: resp0_val=%b result=%0d req_rdy=%b%b mul_val=%b, required 1 30 00 0",
                        resp0_val, resp0_msg_result, req0_rdy, req1_rdy, mul_val);
    end
    resp0_rdy = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok || last1 !== 64'd6) begin
      fails++; $display("FAIL stall_followup: drained=%b resp1=%0d, required 1 6", ok, last1);
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    @(negedge clk);
    stim0.push_back({32'd1, 32'd2});
    wait_drain(ok);
    stim0.push_back({32'd9, 32'd9});
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mul_resp_rdy) begin ok = 1'b1; break; end
    end
    pulse_reset();
    @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b0 || resp0_val !== 1'b0 || resp1_val !== 1'b0 ||
        mul_val !== 1'b0 || mul_resp_rdy !== 1'b0) begin
      fails++; $display("FAIL reset_abandon: reached_wait=%b busy=%b vals=%b%b%b, required 1 0 000",
                        ok, busy, resp0_val, resp1_val, mul_val);
    end
    got_order.delete();
    stim0.push_back({32'd1, 32'd1});
    stim1.push_back({32'd2, 32'd2});
    wait_drain(ok);
    checks++;
    if (!ok || got_order.size() != 2 || got_order[0] != 1'b0) begin
      fails++; $display("FAIL reset_prio: drained=%b n=%0d first=%0d, required 1 2 0",
                        ok, got_order.size(), got_order.size() > 0 ? int'(got_order[0]) : -1);
    end
    @(negedge clk);
    stim1.push_back({32'd4, 32'd4});
    wait_drain(ok);
    checks++;
    if (!ok || last1 !== 64'd16) begin
      fails++; $display("FAIL reset_followup: drained=%b resp1=%0d, required 1 16", ok, last1);
    end
  endtask

  task automatic test_zero_operand();
    bit ok;
    int fires;
    fires = mul_fires;
    @(negedge clk);
    stim0.push_back({32'd0, 32'd7});
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_val && req0_rdy) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    checks++;
`ifdef IMULDIV_ARB_ZERO_BYPASS_EN
    if (!ok || resp0_val !== 1'b1 || mul_val !== 1'b0) begin
      fails++; $display("FAIL zero_bypass_latency: accepted=%b resp0_val=%b mul_val=%b, required 1 1 0",
                        ok, resp0_val, mul_val);
    end
`else
    if (!ok || resp0_val !== 1'b0 || mul_val !== 1'b1) begin
      fails++; $display("FAIL zero_via_mul: accepted=%b resp0_val=%b mul_val=%b, required 1 0 1",
                        ok, resp0_val, mul_val);
    end
`endif
    wait_drain(ok);
    checks++;
`ifdef IMULDIV_ARB_ZERO_BYPASS_EN
    if (!ok || last0 !== 64'd0 || mul_fires != fires) begin
      fails++; $display("FAIL zero_result: drained=%b result=%h mul_ops=%0d, required 1 0 0",
                        ok, last0, mul_fires - fires);
    end
`else
    if (!ok || last0 !== 64'd0 || mul_fires != fires + 1) begin
      fails++; $display("FAIL zero_result: drained=%b result=%h mul_ops=%0d, required 1 0 1",
                        ok, last0, mul_fires - fires);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_both_same_cycle();
    test_back_to_back();
    test_resp_stall();
    test_reset_mid_op();
    test_zero_operand();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
